// File: rtl/beer_tap_arbiter.sv
// beer_tap_arbiter: round-robin sequencer sharing one draft unit among N_REQ taps,
// with keg-empty blocking, pour timeout and a saturating pour counter.
module beer_tap_arbiter #(
    parameter int N_REQ     = 4,
    parameter int LEVEL_W   = 4,
    parameter int MIN_LEVEL = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [LEVEL_W-1:0] beer_level,
    input  logic               pour_done,
    output logic [N_REQ-1:0]   grant,
    output logic               draft,
    output logic               busy,
    output logic               keg_empty,
    output logic               timeout_err,
    output logic [7:0]         pour_count,
    output logic [3:0]         state_display
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE = 2'd0, POUR = 2'd1, RELEASE = 2'd2, EMPTY = 2'd3} state_t;
    state_t state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [PW-1:0] ptr, ptr_n, win;
    logic [TW-1:0] timer, timer_n;
    logic [7:0] count_n;
    logic draft_n, terr_n, low_level;
    assign low_level = beer_level < LEVEL_W'(MIN_LEVEL);
    // Walk downward so the closest set bit at or above ptr is the last one written.
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N_REQ]) win = PW'((int'(ptr) + i) % N_REQ);
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        draft_n = 1'b0;
        timer_n = timer;
        ptr_n   = ptr;
        count_n = pour_count;
        terr_n  = timeout_err;
        case (state)
            IDLE: begin
                if (low_level) begin
                    state_n = EMPTY;
                end else if (|req) begin
                    state_n = POUR;
                    grant_n = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    draft_n = 1'b1;
                    timer_n = '0;
                    ptr_n   = PW'((int'(win) + 1) % N_REQ);
                end
            end
            POUR: begin
                timer_n = timer + 1'b1;
                if (pour_done) begin
                    state_n = RELEASE;
                    count_n = (pour_count == 8'hFF) ? pour_count : pour_count + 8'd1;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_n = RELEASE;
                    terr_n  = 1'b1;
                end
            end
            RELEASE: begin
                if ((req & grant) == '0) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            EMPTY: begin
                grant_n = '0;
                if (!low_level) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            draft         <= 1'b0;
            timer         <= '0;
            ptr           <= '0;
            pour_count    <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
            keg_empty     <= 1'b0;
            state_display <= 4'd0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            draft         <= draft_n;
            timer         <= timer_n;
            ptr           <= ptr_n;
            pour_count    <= count_n;
            timeout_err   <= terr_n;
            busy          <= (state_n == POUR) || (state_n == RELEASE);
            keg_empty     <= state_n == EMPTY;
            state_display <= 4'(state_n);
        end
    end
endmodule

// File: tb/tb_beer_tap_arbiter.sv
// tb_beer_tap_arbiter: directed scenario tasks with hand-computed expectations.
module tb_beer_tap_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] beer_level = 4'd5;
    logic       pour_done = 1'b0;
    logic [3:0] grant;
    logic       draft, busy, keg_empty, timeout_err;
    logic [7:0] pour_count;
    logic [3:0] state_display;
    int checks = 0;
    int failures = 0;

    beer_tap_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .beer_level(beer_level), .pour_done(pour_done),
        .grant(grant), .draft(draft), .busy(busy), .keg_empty(keg_empty),
        .timeout_err(timeout_err), .pour_count(pour_count), .state_display(state_display)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; pour_done = 1'b0; beer_level = 4'd5;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (draft !== 1'b0) begin failures++; $display("FAIL reset_draft got=%b exp=0", draft); end
        checks++; if (busy !== 1'b0 || keg_empty !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b keg_empty=%b exp=0/0", busy, keg_empty); end
        checks++; if (timeout_err !== 1'b0 || pour_count !== 8'd0) begin failures++; $display("FAIL reset_stats terr=%b count=%0d exp=0/0", timeout_err, pour_count); end
        checks++; if (state_display !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_display); end
    endtask

    task automatic test_single_pour();
        do_reset();
        req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001 || draft !== 1'b1) begin failures++; $display("FAIL single_grant grant=%b draft=%b exp=0001/1", grant, draft); end
        checks++; if (state_display !== 4'd1 || busy !== 1'b1) begin failures++; $display("FAIL single_pour_state state=%0d busy=%b exp=1/1", state_display, busy); end
        tick();
        checks++; if (draft !== 1'b0) begin failures++; $display("FAIL single_draft_pulse got=%b exp=0", draft); end
        tick();
        pour_done = 1'b1;
        tick();
        pour_done = 1'b0;
        checks++; if (state_display !== 4'd2 || pour_count !== 8'd1 || grant !== 4'b0001) begin failures++; $display("FAIL single_release state=%0d count=%0d grant=%b exp=2/1/0001", state_display, pour_count, grant); end
        req = 4'b0000;
        tick();
        checks++; if (state_display !== 4'd0 || grant !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle state=%0d grant=%b busy=%b exp=0/0000/0", state_display, grant, busy); end
        pour_done = 1'b1;
        tick();
        pour_done = 1'b0;
        checks++; if (pour_count !== 8'd1 || state_display !== 4'd0) begin failures++; $display("FAIL stray_done count=%0d state=%0d exp=1/0", pour_count, state_display); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (grant !== exp_g[k] || draft !== 1'b1) begin failures++; $display("FAIL rr_grant%0d grant=%b draft=%b exp=%b/1", k, grant, draft, exp_g[k]); end
            pour_done = 1'b1;
            tick();
            pour_done = 1'b0;
            req = 4'b1111 & ~exp_g[k];
            tick();
            checks++; if (state_display !== 4'd0 || grant !== 4'b0) begin failures++; $display("FAIL rr_release%0d state=%0d grant=%b exp=0/0000", k, state_display, grant); end
            req = 4'b1111;
        end
        checks++; if (pour_count !== 8'd5) begin failures++; $display("FAIL rr_count got=%0d exp=5", pour_count); end
    endtask

    task automatic test_keg_empty();
        logic saw_draft = 1'b0;
        do_reset();
        beer_level = 4'd0;
        req = 4'b0010;
        tick();
        checks++; if (state_display !== 4'd3 || keg_empty !== 1'b1 || grant !== 4'b0) begin failures++; $display("FAIL empty_enter state=%0d keg=%b grant=%b exp=3/1/0000", state_display, keg_empty, grant); end
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_draft |= draft | (|grant);
        end
        checks++; if (saw_draft !== 1'b0 || state_display !== 4'd3) begin failures++; $display("FAIL empty_block activity=%b state=%0d exp=0/3", saw_draft, state_display); end
        beer_level = 4'd2;
        tick();
        checks++; if (state_display !== 4'd0 || keg_empty !== 1'b0) begin failures++; $display("FAIL empty_exit state=%0d keg=%b exp=0/0", state_display, keg_empty); end
        tick();
        checks++; if (grant !== 4'b0010 || draft !== 1'b1) begin failures++; $display("FAIL empty_resume grant=%b draft=%b exp=0010/1", grant, draft); end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0100;
        tick();
        for (int i = 0; i < 14; i++) tick();
        checks++; if (state_display !== 4'd1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_early state=%0d terr=%b exp=1/0", state_display, timeout_err); end
        tick();
        checks++; if (state_display !== 4'd2 || timeout_err !== 1'b1 || pour_count !== 8'd0) begin failures++; $display("FAIL to_fire state=%0d terr=%b count=%0d exp=2/1/0", state_display, timeout_err, pour_count); end
        req = 4'b0000;
        tick();
        checks++; if (state_display !== 4'd0 || timeout_err !== 1'b1 || grant !== 4'b0) begin failures++; $display("FAIL to_sticky state=%0d terr=%b grant=%b exp=0/1/0000", state_display, timeout_err, grant); end
    endtask

    task automatic test_done_vs_timeout();
        do_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 14; i++) tick();
        pour_done = 1'b1;
        tick();
        pour_done = 1'b0;
        checks++; if (state_display !== 4'd2 || timeout_err !== 1'b0 || pour_count !== 8'd1) begin failures++; $display("FAIL tie state=%0d terr=%b count=%0d exp=2/0/1", state_display, timeout_err, pour_count); end
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL drop_grant got=%b exp=0010", grant); end
        tick();
        req = 4'b0000;
        tick();
        checks++; if (state_display !== 4'd1 || grant !== 4'b0010) begin failures++; $display("FAIL drop_hold state=%0d grant=%b exp=1/0010", state_display, grant); end
        pour_done = 1'b1;
        tick();
        pour_done = 1'b0;
        checks++; if (state_display !== 4'd2 || pour_count !== 8'd2) begin failures++; $display("FAIL drop_release state=%0d count=%0d exp=2/2", state_display, pour_count); end
        tick();
        checks++; if (state_display !== 4'd0 || grant !== 4'b0) begin failures++; $display("FAIL drop_idle state=%0d grant=%b exp=0/0000", state_display, grant); end
    endtask

    task automatic test_reset_mid_pour();
        do_reset();
        req = 4'b1000;
        tick();
        pour_done = 1'b1;
        tick();
        pour_done = 1'b0;
        req = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        checks++; if (grant !== 4'b1000 || state_display !== 4'd1 || pour_count !== 8'd1) begin failures++; $display("FAIL mid_setup grant=%b state=%0d count=%0d exp=1000/1/1", grant, state_display, pour_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (grant !== 4'b0 || state_display !== 4'd0 || pour_count !== 8'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL mid_reset grant=%b state=%0d count=%0d terr=%b exp=0000/0/0/0", grant, state_display, pour_count, timeout_err); end
        req = 4'b1001;
        tick();
        checks++; if (grant !== 4'b0001 || draft !== 1'b1) begin failures++; $display("FAIL mid_ptr grant=%b draft=%b exp=0001/1", grant, draft); end
    endtask

    initial begin
        test_reset();
        test_single_pour();
        test_round_robin();
        test_keg_empty();
        test_timeout();
        test_done_vs_timeout();
        test_reset_mid_pour();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
